// File: rtl/dual_issue_scheduler_pkg.sv
// rtl/dual_issue_scheduler_pkg.sv - opcode constants, scheduler state and instruction classifiers
package sched_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic {PAIR, SECOND} sched_state_t;

  function automatic logic is_mem(input logic [6:0] op);
    return (op == LOAD) || (op == STORE);
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == BRANCH) || (op == JAL) || (op == JALR);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == LUI) || (op == AUIPC) || (op == JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP) || (op == STORE) || (op == BRANCH);
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_pair_hazard_check.sv
// rtl/dual_issue_scheduler_pair_hazard_check.sv - stateless intra-pair hazard detection
module pair_hazard_check
  import sched_pkg::*;
#(
  parameter bit SPLIT_ON_CTRL = 1'b1
) (
  input  logic       valid0,
  input  logic       valid1,
  input  logic [6:0] opcode0,
  input  logic [6:0] opcode1,
  input  logic [4:0] rd0,
  input  logic [4:0] rd1,
  input  logic [4:0] rs1_1,
  input  logic [4:0] rs2_1,
  input  logic       regwrite0,
  input  logic       regwrite1,
  output logic       conflict,
  output logic       cause_mem,
  output logic       cause_raw,
  output logic       cause_waw,
  output logic       cause_ctrl
);

  logic rd0_live;

  assign rd0_live   = regwrite0 && (rd0 != 5'd0);

  // Only one pipe has a data-memory port
  assign cause_mem  = is_mem(opcode0) && is_mem(opcode1);
  assign cause_raw  = rd0_live &&
                      ((uses_rs1(opcode1) && (rs1_1 == rd0)) ||
                       (uses_rs2(opcode1) && (rs2_1 == rd0)));
  assign cause_waw  = rd0_live && regwrite1 && (rd0 == rd1);
  assign cause_ctrl = SPLIT_ON_CTRL && is_ctrl(opcode0);

  assign conflict   = valid0 && valid1 &&
                      (cause_mem || cause_raw || cause_waw || cause_ctrl);

endmodule

// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - steers a decoded pair onto the ALU pipe and the ALU+memory pipe
module dual_issue_scheduler
  import sched_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter bit SPLIT_ON_CTRL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid0,
  input  logic             valid1,
  input  logic [6:0]       opcode0,
  input  logic [6:0]       opcode1,
  input  logic [4:0]       rd0,
  input  logic [4:0]       rd1,
  input  logic [4:0]       rs1_1,
  input  logic [4:0]       rs2_1,
  input  logic             regwrite0,
  input  logic             regwrite1,
  input  logic             hold,
  input  logic             flush,
  output logic             issue_p0,
  output logic             issue_p1,
  output logic             src_p0,
  output logic             src_p1,
  output logic             older_pipe,
  output logic             stall_fd,
  output logic [CNT_W-1:0] split_cnt
);

  sched_state_t state, state_nxt;

  logic conflict, cause_mem, cause_raw, cause_waw, cause_ctrl;
  logic mem0, mem1;
  logic issue0_c, issue1_c, src0_c, src1_c, older_c, stall_c, split_inc;

  assign mem0 = is_mem(opcode0);
  assign mem1 = is_mem(opcode1);

  pair_hazard_check #(
    .SPLIT_ON_CTRL (SPLIT_ON_CTRL)
  ) u_hazard (
    .valid0     (valid0),
    .valid1     (valid1),
    .opcode0    (opcode0),
    .opcode1    (opcode1),
    .rd0        (rd0),
    .rd1        (rd1),
    .rs1_1      (rs1_1),
    .rs2_1      (rs2_1),
    .regwrite0  (regwrite0),
    .regwrite1  (regwrite1),
    .conflict   (conflict),
    .cause_mem  (cause_mem),
    .cause_raw  (cause_raw),
    .cause_waw  (cause_waw),
    .cause_ctrl (cause_ctrl)
  );

  always_comb begin
    assert (!conflict || cause_mem || cause_raw || cause_waw || cause_ctrl);
  end

  always_comb begin
    issue0_c  = 1'b0;
    issue1_c  = 1'b0;
    src0_c    = 1'b0;
    src1_c    = 1'b1;
    older_c   = 1'b0;
    stall_c   = 1'b0;
    split_inc = 1'b0;
    state_nxt = state;

    if (state == SECOND) begin
      // Second half of a split: only the younger instruction remains
      if (mem1) begin
        issue1_c = valid1;
        older_c  = 1'b1;
      end else begin
        issue0_c = valid1;
        src0_c   = 1'b1;
      end
      state_nxt = PAIR;
    end else if (conflict) begin
      if (mem0) begin
        issue1_c = 1'b1;
        src1_c   = 1'b0;
        older_c  = 1'b1;
      end else begin
        issue0_c = 1'b1;
      end
      stall_c   = 1'b1;
      split_inc = 1'b1;
      state_nxt = SECOND;
    end else if (valid0 && valid1) begin
      issue0_c = 1'b1;
      issue1_c = 1'b1;
      if (mem0 && !mem1) begin
        src0_c  = 1'b1;
        src1_c  = 1'b0;
        older_c = 1'b1;
      end
    end else if (valid0) begin
      if (mem0) begin
        issue1_c = 1'b1;
        src1_c   = 1'b0;
        older_c  = 1'b1;
      end else begin
        issue0_c = 1'b1;
      end
    end else if (valid1) begin
      if (mem1) begin
        issue1_c = 1'b1;
        older_c  = 1'b1;
      end else begin
        issue0_c = 1'b1;
        src0_c   = 1'b1;
      end
    end

    // Steering selects stay as computed so the ID/EX muxes see stable values
    if (flush) begin
      issue0_c  = 1'b0;
      issue1_c  = 1'b0;
      stall_c   = 1'b0;
      split_inc = 1'b0;
      state_nxt = PAIR;
    end else if (hold) begin
      issue0_c  = 1'b0;
      issue1_c  = 1'b0;
      stall_c   = 1'b1;
      split_inc = 1'b0;
      state_nxt = state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PAIR;
      split_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (split_inc && (split_cnt != {CNT_W{1'b1}})) begin
        split_cnt <= split_cnt + 1'b1;
      end
    end
  end

  assign issue_p0   = rst && issue0_c;
  assign issue_p1   = rst && issue1_c;
  assign src_p0     = rst && src0_c;
  assign src_p1     = rst && src1_c;
  assign older_pipe = rst && older_c;
  assign stall_fd   = rst && stall_c;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - directed self-checking bench for dual_issue_scheduler
module tb_dual_issue_scheduler;

  localparam int CNT_W = 3;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic             clk;
  logic             rst;
  logic             valid0, valid1;
  logic [6:0]       opcode0, opcode1;
  logic [4:0]       rd0, rd1, rs1_1, rs2_1;
  logic             regwrite0, regwrite1;
  logic             hold, flush;
  logic             issue_p0, issue_p1, src_p0, src_p1, older_pipe, stall_fd;
  logic [CNT_W-1:0] split_cnt;
  logic [5:0]       obs;

  int asserts  = 0;
  int failures = 0;
  int exp_cnt  = 0;

  dual_issue_scheduler #(
    .CNT_W         (CNT_W),
    .SPLIT_ON_CTRL (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid0     (valid0),
    .valid1     (valid1),
    .opcode0    (opcode0),
    .opcode1    (opcode1),
    .rd0        (rd0),
    .rd1        (rd1),
    .rs1_1      (rs1_1),
    .rs2_1      (rs2_1),
    .regwrite0  (regwrite0),
    .regwrite1  (regwrite1),
    .hold       (hold),
    .flush      (flush),
    .issue_p0   (issue_p0),
    .issue_p1   (issue_p1),
    .src_p0     (src_p0),
    .src_p1     (src_p1),
    .older_pipe (older_pipe),
    .stall_fd   (stall_fd),
    .split_cnt  (split_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {issue_p0, issue_p1, src_p0, src_p1, older_pipe, stall_fd}
  assign obs = {issue_p0, issue_p1, src_p0, src_p1, older_pipe, stall_fd};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic v1, input logic [6:0] op0,
                       input logic [6:0] op1, input logic [4:0] d0, input logic [4:0] d1,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic w0, input logic w1);
    valid0 = v0; valid1 = v1; opcode0 = op0; opcode1 = op1;
    rd0 = d0; rd1 = d1; rs1_1 = s1; rs2_1 = s2;
    regwrite0 = w0; regwrite1 = w1;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, OPC_OP, OPC_OP, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; hold = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, OPC_OP, OPC_OP, 5'd5, 5'd7, 5'd6, 5'd8, 1'b1, 1'b1);
    asserts++;
    if (obs !== 6'b000000) begin
      $display("FAIL reset_outputs: got %b expected %b", obs, 6'b000000); failures++;
    end
    asserts++;
    if (split_cnt !== 3'd0) begin
      $display("FAIL reset_cnt: got %0d expected 0", split_cnt); failures++;
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_dual_add();
    drive(1'b1, 1'b1, OPC_OP, OPC_OP, 5'd5, 5'd7, 5'd6, 5'd8, 1'b1, 1'b1);
    asserts++;
    if (obs !== 6'b110100) begin
      $display("FAIL dual_add: got %b expected %b", obs, 6'b110100); failures++;
    end
    tick();
  endtask

  task automatic test_swap();
    drive(1'b1, 1'b1, OPC_LOAD, OPC_OP, 5'd5, 5'd7, 5'd6, 5'd8, 1'b1, 1'b1);
    asserts++;
    if (obs !== 6'b111010) begin
      $display("FAIL swap: got %b expected %b", obs, 6'b111010); failures++;
    end
    tick();
  endtask

  task automatic test_mem_mem();
    drive(1'b1, 1'b1, OPC_LOAD, OPC_STORE, 5'd5, 5'd0, 5'd6, 5'd7, 1'b1, 1'b0);
    asserts++;
    if (obs !== 6'b010011) begin
      $display("FAIL mem_mem_c1: got %b expected %b", obs, 6'b010011); failures++;
    end
    tick();
    exp_cnt++;
    #2;
    asserts++;
    if (obs !== 6'b010110) begin
      $display("FAIL mem_mem_c2: got %b expected %b", obs, 6'b010110); failures++;
    end
    asserts++;
    if (split_cnt !== 3'(exp_cnt)) begin
      $display("FAIL mem_mem_cnt: got %0d expected %0d", split_cnt, exp_cnt); failures++;
    end
    tick();
  endtask

  task automatic test_raw();
    drive(1'b1, 1'b1, OPC_OP, OPC_OP, 5'd3, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1);
    asserts++;
    if (obs !== 6'b100101) begin
      $display("FAIL raw_c1: got %b expected %b", obs, 6'b100101); failures++;
    end
    tick();
    exp_cnt++;
    #2;
    asserts++;
    if (obs !== 6'b101100) begin
      $display("FAIL raw_c2: got %b expected %b", obs, 6'b101100); failures++;
    end
    asserts++;
    if (split_cnt !== 3'(exp_cnt)) begin
      $display("FAIL raw_cnt: got %0d expected %0d", split_cnt, exp_cnt); failures++;
    end
    tick();
    drive(1'b1, 1'b1, OPC_OP, OPC_OP, 5'd0, 5'd9, 5'd0, 5'd4, 1'b1, 1'b1);
    asserts++;
    if (obs !== 6'b110100) begin
      $display("FAIL raw_x0: got %b expected %b", obs, 6'b110100); failures++;
    end
    tick();
  endtask

  task automatic test_ctrl();
    drive(1'b1, 1'b1, OPC_BRANCH, OPC_OP, 5'd0, 5'd7, 5'd6, 5'd8, 1'b0, 1'b1);
    asserts++;
    if (obs !== 6'b100101) begin
      $display("FAIL ctrl_split: got %b expected %b", obs, 6'b100101); failures++;
    end
    tick();
    exp_cnt++;
    idle();
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, OPC_OP, OPC_OP, 5'd3, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1);
    tick();
    exp_cnt++;
    flush = 1'b1;
    #2;
    asserts++;
    if (obs !== 6'b001100) begin
      $display("FAIL flush_second: got %b expected %b", obs, 6'b001100); failures++;
    end
    tick();
    flush = 1'b0;
    drive(1'b1, 1'b1, OPC_OP, OPC_OP, 5'd5, 5'd7, 5'd6, 5'd8, 1'b1, 1'b1);
    asserts++;
    if (obs !== 6'b110100) begin
      $display("FAIL flush_to_pair: got %b expected %b", obs, 6'b110100); failures++;
    end
    tick();
  endtask

  task automatic test_hold();
    hold = 1'b1;
    drive(1'b1, 1'b1, OPC_OP, OPC_OP, 5'd3, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1);
    asserts++;
    if (obs !== 6'b000101) begin
      $display("FAIL hold_outputs: got %b expected %b", obs, 6'b000101); failures++;
    end
    tick();
    tick();
    asserts++;
    if (split_cnt !== 3'(exp_cnt)) begin
      $display("FAIL hold_cnt: got %0d expected %0d", split_cnt, exp_cnt); failures++;
    end
    hold = 1'b0;
    #2;
    asserts++;
    if (obs !== 6'b100101) begin
      $display("FAIL hold_release: got %b expected %b", obs, 6'b100101); failures++;
    end
    tick();
    exp_cnt++;
    asserts++;
    if (split_cnt !== 3'(exp_cnt)) begin
      $display("FAIL hold_release_cnt: got %0d expected %0d", split_cnt, exp_cnt); failures++;
    end
    idle();
    tick();
  endtask

  task automatic test_lone();
    drive(1'b0, 1'b1, OPC_OP, OPC_LOAD, 5'd0, 5'd7, 5'd6, 5'd0, 1'b0, 1'b1);
    asserts++;
    if (obs !== 6'b010110) begin
      $display("FAIL lone_slot1_mem: got %b expected %b", obs, 6'b010110); failures++;
    end
    tick();
    idle();
    asserts++;
    if (obs !== 6'b000100) begin
      $display("FAIL no_valid: got %b expected %b", obs, 6'b000100); failures++;
    end
    tick();
  endtask

  task automatic test_saturate();
    drive(1'b1, 1'b1, OPC_OP, OPC_OP, 5'd3, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
    end
    exp_cnt = (exp_cnt + 8 > 7) ? 7 : exp_cnt + 8;
    asserts++;
    if (split_cnt !== 3'(exp_cnt)) begin
      $display("FAIL saturate: got %0d expected %0d", split_cnt, exp_cnt); failures++;
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_split();
    drive(1'b1, 1'b1, OPC_OP, OPC_OP, 5'd3, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    #2;
    asserts++;
    if (obs !== 6'b000000) begin
      $display("FAIL reset_mid_outputs: got %b expected %b", obs, 6'b000000); failures++;
    end
    asserts++;
    if (split_cnt !== 3'd0) begin
      $display("FAIL reset_mid_cnt: got %0d expected 0", split_cnt); failures++;
    end
    rst = 1'b1;
    #2;
    asserts++;
    if (obs !== 6'b100101) begin
      $display("FAIL reset_mid_pair: got %b expected %b", obs, 6'b100101); failures++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_dual_add();
    test_swap();
    test_mem_mem();
    test_raw();
    test_ctrl();
    test_flush();
    test_hold();
    test_lone();
    test_saturate();
    test_reset_mid_split();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- Steers the two decoded instructions (slot 0 is older, slot 1 is younger) onto pipeline 0 (ALU-only) and pipeline 1 (ALU plus data memory) each cycle.
- Detects structural and intra-pair hazards. On a hazard it splits the pair over two cycles and stalls fetch/decode meanwhile.
- Sits between the decode stage and the ID/EX registers. It drives the operand/control swap muxes and the per-pipe issue valids.

Parameters:
CNT_W, 16, width of the saturating split-event counter
SPLIT_ON_CTRL, 1, 1 = a branch/jump in slot 0 always issues alone

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
valid0  in  1  slot 0 holds a real instruction
valid1  in  1  slot 1 holds a real instruction
opcode0  in  7  slot 0 opcode
opcode1  in  7  slot 1 opcode
rd0  in  5  slot 0 destination register
rd1  in  5  slot 1 destination register
rs1_1  in  5  slot 1 source register 1
rs2_1  in  5  slot 1 source register 2
regwrite0  in  1  slot 0 writes rd
regwrite1  in  1  slot 1 writes rd
hold  in  1  downstream stall; freeze the scheduler
flush  in  1  branch/jump redirect; kill the pair
issue_p0  out  1  pipeline 0 receives a valid instruction
issue_p1  out  1  pipeline 1 receives a valid instruction
src_p0  out  1  slot feeding pipeline 0 (0 = slot 0, 1 = slot 1)
src_p1  out  1  slot feeding pipeline 1
older_pipe  out  1  pipe holding the program-order-older instruction
stall_fd  out  1  hold the fetch and IF/ID registers
split_cnt  out  CNT_W  number of split events

Behaviour:
- Reset:
  - While rst is low: state = PAIR, split_cnt = 0.
  - While rst is low, all other outputs are forced to 0.
- Classification:
  - mem(x) = opcode is LOAD 0000011 or STORE 0100011.
  - ctrl(x) = opcode is BRANCH 1100011, JAL 1101111 or JALR 1100111.
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used by R-type, STORE and BRANCH.
- Hazard flag `conflict` is set when valid0 & valid1 and any of the following holds:
  - mem0 & mem1.
  - RAW: regwrite0, rd0 != 0, and rd0 matches a used rs of slot 1.
  - WAW: regwrite0 & regwrite1 & rd0 == rd1 != 0.
  - SPLIT_ON_CTRL & ctrl0.
- Outputs are combinational from state and inputs (Mealy). Decisions take zero cycles; the only registered items are state and split_cnt.
- State PAIR, no conflict:
  - Steering when mem0 & !mem1 (swap): src_p1 = 0, src_p0 = 1, older_pipe = 1.
  - Steering otherwise (straight): src_p0 = 0, src_p1 = 1, older_pipe = 0.
  - issue_p0 / issue_p1 = valid of the slot each pipe receives.
  - A lone mem instruction always goes to pipeline 1.
  - stall_fd = 0.
- State PAIR, conflict:
  - Issue slot 0 only, on pipe 1 if mem0, else on pipe 0. Older_pipe = that pipe.
  - stall_fd = 1.
  - Next state = SECOND; split_cnt += 1, saturating at all-ones.
- State SECOND:
  - Issue slot 1 only, on pipe 1 if mem1, else on pipe 0. Older_pipe = that pipe.
  - stall_fd = 0.
  - Next state = PAIR.
- hold = 1:
  - issue_p0 = issue_p1 = 0, stall_fd = 1.
  - State and split_cnt are unchanged.
  - Steering outputs keep the value they would otherwise have.
- flush = 1 (has priority over hold):
  - issue_p0 = issue_p1 = 0, stall_fd = 0.
  - Next state = PAIR; split_cnt unchanged.
- Reset asserted in SECOND: return to PAIR immediately; the pending slot 1 is dropped.
- valid0 = 0 & valid1 = 1: slot 1 issues alone with no split, steered by mem1.
- Both valids 0: no issue, no stall, state unchanged.
- The unused src_* select is don't-care. It is driven to the straight value (src_p0 = 0, src_p1 = 1).

Decomposition:
- Package sched_pkg holds:
  - Opcode constants LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP_IMM.
  - typedef enum logic {PAIR, SECOND} sched_state_t.
  - Functions is_mem, is_ctrl, uses_rs1, uses_rs2.
- One sub-module, pair_hazard_check: combinational and stateless, producing conflict and its cause bits (mem, raw, waw, ctrl) for debug.

Test Plan:
- Two independent ADDs (opcode 0110011, rd0 = 5, rs1_1 = 6) -> issue_p0 = issue_p1 = 1, src_p0 = 0, src_p1 = 1, older_pipe = 0, stall_fd = 0.
- LW in slot 0, ADD in slot 1, no dependency -> swap: src_p1 = 0, src_p0 = 1, older_pipe = 1, both issue.
- LW then SW -> cycle 1: issue_p1 only with src_p1 = 0, stall_fd = 1; cycle 2: issue_p1 only with src_p1 = 1, stall_fd = 0; split_cnt = 1.
- RAW pair, ADD x3 then SUB reading x3 -> two-cycle split, both issues on pipe 0. The same pair with rd0 = x0 -> dual issue, no split.
- Flush asserted in SECOND -> no issue that cycle, state returns to PAIR. With hold in PAIR under a conflict, state is held and split_cnt does not increment until hold falls.
- Force split_cnt to all-ones, then split again -> split_cnt stays at all-ones. Pulse rst low mid-split -> all outputs 0 and state = PAIR.
